// File: rtl/axi_ram_slave.sv
// AXI4 responder backed by an on-chip word RAM.
// Independent read and write engines, each with one outstanding transaction.
module axi_ram_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_WORDS_LOG2   = 12,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int MW = C_MEM_WORDS_LOG2;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {R_IDLE, R_MEM, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

    // Beats of WRAP/reserved bursts and non-word sizes are served as INCR but flagged.
    function automatic logic beat_flag(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) | burst[1];
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr);
        return addr + AW'(4);
    endfunction

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:(1<<MW)-1];

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    logic [AW-1:0] rd_addr, wr_addr, rd_off, wr_off;
    logic [7:0]    rd_len, wr_len, rd_cnt, wr_cnt;
    logic          rd_fixed, wr_fixed, rd_flag, wr_flag, wr_err;
    logic [MW-1:0] rd_idx, wr_idx;
    logic          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic          rd_last_beat, wr_last_beat, rd_beat_err, wr_beat_err, wr_err_next;
    logic          arready_d, rvalid_d, awready_d, wready_d, bvalid_d;
    logic          unused_bits;

    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID  & S_AXI_RREADY;
    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign b_hs  = S_AXI_BVALID  & S_AXI_BREADY;

    assign rd_off       = rd_addr - C_BASE_ADDR;
    assign wr_off       = wr_addr - C_BASE_ADDR;
    assign rd_idx       = rd_off[MW+1:2];
    assign wr_idx       = wr_off[MW+1:2];
    assign rd_beat_err  = rd_flag | (rd_off[AW-1:MW+2] != '0);
    assign wr_beat_err  = wr_flag | (wr_off[AW-1:MW+2] != '0);
    assign rd_last_beat = (rd_cnt == rd_len);
    assign wr_last_beat = (wr_cnt == wr_len);
    assign wr_err_next  = wr_err | wr_beat_err | (S_AXI_WLAST != wr_last_beat);
    assign unused_bits  = &{1'b0, rd_off[1:0], wr_off[1:0]};

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_MEM;
            R_MEM:   rd_next = R_DATA;
            R_DATA:  if (r_hs) rd_next = rd_last_beat ? R_IDLE : R_MEM;
            default: rd_next = R_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        arready_d = (rd_next == R_IDLE);
        rvalid_d  = (rd_next == R_DATA);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_state      <= R_IDLE;
            rd_cnt        <= '0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RID     <= '0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RLAST   <= 1'b0;
        end else begin
            rd_state      <= rd_next;
            S_AXI_ARREADY <= arready_d;
            S_AXI_RVALID  <= rvalid_d;
            if (ar_hs) begin
                rd_cnt    <= '0;
                S_AXI_RID <= S_AXI_ARID;
            end else if (r_hs && !rd_last_beat) begin
                rd_cnt <= rd_cnt + 8'd1;
            end
            if (rd_state == R_MEM) begin
                S_AXI_RDATA <= rd_beat_err ? '0 : mem[rd_idx];
                S_AXI_RRESP <= rd_beat_err ? 2'b10 : 2'b00;
                S_AXI_RLAST <= rd_last_beat;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (ar_hs) begin
            rd_addr  <= S_AXI_ARADDR;
            rd_len   <= S_AXI_ARLEN;
            rd_fixed <= (S_AXI_ARBURST == 2'b00);
            rd_flag  <= beat_flag(S_AXI_ARSIZE, S_AXI_ARBURST);
        end else if (r_hs && !rd_fixed) begin
            rd_addr <= next_addr(rd_addr);
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (aw_hs) wr_next = W_DATA;
            W_DATA:  if (w_hs && wr_last_beat) wr_next = W_RESP;
            W_RESP:  if (b_hs) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready_d = (wr_next == W_IDLE);
        wready_d  = (wr_next == W_DATA);
        bvalid_d  = (wr_next == W_RESP);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_state      <= W_IDLE;
            wr_cnt        <= '0;
            wr_err        <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= 2'b00;
        end else begin
            wr_state      <= wr_next;
            S_AXI_AWREADY <= awready_d;
            S_AXI_WREADY  <= wready_d;
            S_AXI_BVALID  <= bvalid_d;
            if (aw_hs) begin
                wr_cnt    <= '0;
                wr_err    <= 1'b0;
                S_AXI_BID <= S_AXI_AWID;
            end else if (w_hs) begin
                wr_err <= wr_err_next;
                if (wr_last_beat)
                    S_AXI_BRESP <= wr_err_next ? 2'b10 : 2'b00;
                else
                    wr_cnt <= wr_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (aw_hs) begin
            wr_addr  <= S_AXI_AWADDR;
            wr_len   <= S_AXI_AWLEN;
            wr_fixed <= (S_AXI_AWBURST == 2'b00);
            wr_flag  <= beat_flag(S_AXI_AWSIZE, S_AXI_AWBURST);
        end else if (w_hs && !wr_fixed) begin
            wr_addr <= next_addr(wr_addr);
        end
    end

    // Nonblocking write against the read above gives read-first on a same-word collision.
    always_ff @(posedge CLK) begin
        if (w_hs && !wr_beat_err) begin
            for (int i = 0; i < SW; i++) begin
                if (S_AXI_WSTRB[i])
                    mem[wr_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed and randomized bench for axi_ram_slave against a word-array reference model.
module tb_axi_ram_slave;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 4096;

    logic        CLK, RST;
    logic [0:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_ram_slave dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input int k, input logic [1:0] burst);
        return (burst == 2'b00) ? addr : addr + 32'(4 * k);
    endfunction

    function automatic bit beat_err(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] off;
        off = a - BASE;
        return (size != 3'd2) || (burst > 2'd1) || ((off >> 2) >= 32'(DEPTH));
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'(DEPTH - 1));
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input bit early_last);
        bit err = 0;
        for (int k = 0; k <= len; k++) begin
            logic [31:0] a;
            bit wl;
            a  = beat_addr(addr, k, burst);
            wl = early_last ? (k == 0) : (k == len);
            if (wl != (k == len)) err = 1;
            if (beat_err(a, size, burst)) err = 1;
            else
                for (int i = 0; i < 4; i++)
                    if (ws[k][i]) model[word_idx(a)][8*i +: 8] = wd[k][8*i +: 8];
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic do_write(input string tag, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input bit early_last);
        logic [1:0] exp_resp;
        logic [0:0] exp_id;
        int n;
        exp_id   = 1'($urandom);
        exp_resp = model_write(addr, len, size, burst, early_last);
        awid = exp_id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 40) begin tick(); n++; end
        tick();
        awvalid = 1'b0;
        check({tag, "_aw_wait"}, 32'(n < 40), 32'd1);
        if (n >= 40) return;
        for (int k = 0; k <= len; k++) begin
            wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k];
            wlast  = early_last ? (k == 0) : (k == len);
            n = 0;
            while (!wready && n < 40) begin tick(); n++; end
            tick();
            if (n >= 40) begin
                check({tag, "_w_wait"}, 32'(n), 32'd0);
                wvalid = 1'b0;
                return;
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 40) begin tick(); n++; end
        check({tag, "_b_wait"}, 32'(n < 40), 32'd1);
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        check({tag, "_bid"}, 32'(bid), 32'(exp_id));
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_n, input bit chk_lat);
        logic [0:0]  exp_id;
        logic [31:0] a, ed;
        logic [1:0]  er;
        int n, hs_cyc;
        exp_id = 1'($urandom);
        arid = exp_id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 40) begin tick(); n++; end
        hs_cyc = cyc;
        tick();
        arvalid = 1'b0;
        check({tag, "_ar_wait"}, 32'(n < 40), 32'd1);
        if (n >= 40) return;
        for (int k = 0; k <= len; k++) begin
            a = beat_addr(addr, k, burst);
            if (beat_err(a, size, burst)) begin ed = 32'h0; er = 2'b10; end
            else begin ed = model[word_idx(a)]; er = 2'b00; end
            rready = (k != stall_beat);
            n = 0;
            while (!rvalid && n < 40) begin tick(); n++; end
            if (n >= 40) begin
                check({tag, "_r_wait"}, 32'(n), 32'd0);
                rready = 1'b0;
                return;
            end
            if (chk_lat && k == 0) check({tag, "_latency"}, 32'(cyc - hs_cyc), 32'd2);
            if (k == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check({tag, "_stall_valid"}, 32'(rvalid), 32'd1);
                    check({tag, "_stall_data"}, rdata, ed);
                    check({tag, "_stall_last"}, 32'(rlast), 32'(k == len));
                end
                rready = 1'b1;
            end
            check($sformatf("%s_data%0d", tag, k), rdata, ed);
            check($sformatf("%s_resp%0d", tag, k), 32'(rresp), 32'(er));
            check($sformatf("%s_last%0d", tag, k), 32'(rlast), 32'(k == len));
            check($sformatf("%s_rid%0d", tag, k), 32'(rid), 32'(exp_id));
            tick();
            rready = 1'b0;
        end
    endtask

    initial begin
        int kind, len, n, sb;
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [2:0]  size;

        RST = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) tick();
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        RST = 1'b1;
        tick();
        check("post_rst_arready", 32'(arready), 32'd1);
        check("post_rst_awready", 32'(awready), 32'd1);

        // Single write then read with latency check
        wd[0] = 32'h0BAD_F00D; ws[0] = 4'hF;
        do_write("w_word0", 32'h0, 0, 3'd2, 2'b01, 0);
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write("w_10", 32'h10, 0, 3'd2, 2'b01, 0);
        do_read("r_10", 32'h10, 0, 3'd2, 2'b01, -1, 0, 1);

        // Byte strobes: 0x11223344 merged with 0xAABBCCDD on lanes 0 and 2
        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        do_write("w_20a", 32'h20, 0, 3'd2, 2'b01, 0);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
        do_write("w_20b", 32'h20, 0, 3'd2, 2'b01, 0);
        check("strb_model", model[word_idx(32'h20)], 32'h11BB_33DD);
        do_read("r_20", 32'h20, 0, 3'd2, 2'b01, -1, 0, 0);

        // INCR burst of four, readback stalled on beat 2
        for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
        do_write("w_incr", 32'h100, 3, 3'd2, 2'b01, 0);
        do_read("r_incr", 32'h100, 3, 3'd2, 2'b01, 1, 5, 0);

        // Out of range accesses; word 0 aliases the dropped index bits and must survive
        do_read("r_oor", 32'h4000, 0, 3'd2, 2'b01, -1, 0, 0);
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write("w_oor", 32'h4000, 0, 3'd2, 2'b01, 0);
        do_read("r_word0", 32'h0, 0, 3'd2, 2'b01, -1, 0, 0);

        // Early WLAST: both beats still taken, error response
        wd[0] = 32'h5555_0001; wd[1] = 32'h5555_0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write("w_early", 32'h30, 1, 3'd2, 2'b01, 1);
        do_read("r_early", 32'h30, 1, 3'd2, 2'b01, -1, 0, 0);

        // WSTRB=0 leaves memory untouched with OKAY
        wd[0] = 32'h0; ws[0] = 4'h0;
        do_write("w_nostrb", 32'h20, 0, 3'd2, 2'b01, 0);
        do_read("r_nostrb", 32'h20, 0, 3'd2, 2'b01, -1, 0, 0);

        // FIXED burst hits the same word every beat
        for (int k = 0; k < 3; k++) begin wd[k] = 32'hC0DE_0000 + 32'(k); ws[k] = 4'hF; end
        do_write("w_fixed", 32'h40, 2, 3'd2, 2'b00, 0);
        do_read("r_fixed", 32'h40, 2, 3'd2, 2'b00, -1, 0, 0);

        // Bad size and WRAP are flagged per beat
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        do_write("w_50", 32'h50, 0, 3'd2, 2'b01, 0);
        wd[0] = 32'h8765_4321; ws[0] = 4'hF;
        do_write("w_badsize", 32'h50, 0, 3'd1, 2'b01, 0);
        do_read("r_badsize", 32'h50, 0, 3'd1, 2'b01, -1, 0, 0);
        do_read("r_wrap", 32'h50, 1, 3'd2, 2'b10, -1, 0, 0);
        do_read("r_50", 32'h50, 0, 3'd2, 2'b01, -1, 0, 0);

        // Reset in the middle of a four-beat read
        araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arid = 1'b0;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 40) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 40) begin tick(); n++; end
        check("mid_b1_data", rdata, model[word_idx(32'h100)]);
        tick();
        #2 RST = 1'b0;
        #1;
        check("mid_rvalid", 32'(rvalid), 32'd0);
        check("mid_arready", 32'(arready), 32'd0);
        check("mid_rlast", 32'(rlast), 32'd0);
        check("mid_awready", 32'(awready), 32'd0);
        rready = 1'b0;
        tick();
        check("mid_hold_arready", 32'(arready), 32'd0);
        #2 RST = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rel_arready", 32'(arready), 32'd1);
        do_read("r_after_rst", 32'h10, 0, 3'd2, 2'b01, -1, 0, 1);

        // Known contents for the random region, then mixed random traffic
        for (int k = 0; k < 64; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write("w_fill", 32'h200, 63, 3'd2, 2'b01, 0);
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            addr = 32'h200 + 32'(4 * $urandom_range(0, 48)) + 32'($urandom_range(0, 3));
            len  = $urandom_range(0, 3);
            n    = $urandom_range(0, 9);
            burst = (n < 5) ? 2'b01 : (n < 8) ? 2'b00 : (n == 8) ? 2'b10 : 2'b11;
            size  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            if (kind < 2) begin
                for (int k = 0; k <= len; k++) begin
                    wd[k] = $urandom;
                    ws[k] = 4'($urandom);
                end
                do_write($sformatf("rw%0d", it), addr, len, size, burst,
                         ($urandom_range(0, 5) == 0));
            end else begin
                sb = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, len);
                do_read($sformatf("rr%0d", it), addr, len, size, burst,
                        sb, $urandom_range(1, 3), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
